// File: rtl/prog_rate_div_if.sv
// Control and status bundle for the programmable rate divider:
// per-channel enables, the half-period load handshake and the divided outputs.
interface prog_rate_div_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] iEn;
  logic              iLoad_valid;
  logic [CH_W-1:0]   iLoad_ch;
  logic [CNT_W-1:0]  iLoad_half;
  logic              oLoad_ready;
  logic [NUM_CH-1:0] oClk;
  logic [NUM_CH-1:0] oTick;

  modport master (
    output iEn, iLoad_valid, iLoad_ch, iLoad_half,
    input  oLoad_ready, oClk, oTick
  );

  modport slave (
    input  iEn, iLoad_valid, iLoad_ch, iLoad_half,
    output oLoad_ready, oClk, oTick
  );
endinterface

// File: rtl/prog_rate_div.sv
// Multi-channel programmable clock divider producing 50%-duty square waves and
// rising-edge ticks; new half-periods are swapped in only at level boundaries.
module prog_rate_div #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 32,
  parameter int DEFAULT_HALF = 50_000_000
) (
  input logic            iClk,
  input logic            iRSt_n,
  prog_rate_div_if.slave divBus
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  // A zero half-period is meaningless, so it is promoted to one cycle.
  localparam logic [CNT_W-1:0] RESET_HALF =
    (DEFAULT_HALF == 0) ? ONE : CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0]  r_half [NUM_CH];
  logic [CNT_W-1:0]  r_cnt  [NUM_CH];
  logic [CNT_W-1:0]  r_pend [NUM_CH];
  logic [NUM_CH-1:0] r_pv;
  logic [NUM_CH-1:0] r_clk;
  logic [NUM_CH-1:0] r_tick;

  logic              w_ready;
  logic [NUM_CH-1:0] w_accept;
  logic [NUM_CH-1:0] w_bound;
  logic [CNT_W-1:0]  w_loadVal;

  // Out-of-range channel indices find no match and stay ready, so they are swallowed.
  always_comb begin
    w_ready   = 1'b1;
    w_accept  = '0;
    w_bound   = '0;
    w_loadVal = (divBus.iLoad_half == '0) ? ONE : divBus.iLoad_half;
    for (int i = 0; i < NUM_CH; i++) begin
      if (divBus.iLoad_ch == CH_W'(i)) begin
        w_ready = ~r_pv[i];
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      w_accept[i] = divBus.iLoad_valid && w_ready && (divBus.iLoad_ch == CH_W'(i));
      w_bound[i]  = (r_cnt[i] >= (r_half[i] - ONE));
    end
  end

  always_ff @(posedge iClk or negedge iRSt_n) begin
    if (!iRSt_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_half[i] <= RESET_HALF;
        r_cnt[i]  <= '0;
        r_pend[i] <= '0;
      end
      r_pv   <= '0;
      r_clk  <= '0;
      r_tick <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (divBus.iEn[i]) begin
          if (w_bound[i]) begin
            r_cnt[i]  <= '0;
            r_clk[i]  <= ~r_clk[i];
            r_tick[i] <= ~r_clk[i];
            // Swapping only here keeps every level a whole number of old or new half-periods.
            if (r_pv[i]) begin
              r_half[i] <= r_pend[i];
              r_pv[i]   <= 1'b0;
            end
          end else begin
            r_cnt[i]  <= r_cnt[i] + ONE;
            r_tick[i] <= 1'b0;
          end
        end else begin
          r_cnt[i]  <= '0;
          r_clk[i]  <= 1'b0;
          r_tick[i] <= 1'b0;
          if (r_pv[i]) begin
            r_half[i] <= r_pend[i];
            r_pv[i]   <= 1'b0;
          end
        end
        // Accept only happens with pv low, so it never collides with the apply above.
        if (w_accept[i]) begin
          r_pend[i] <= w_loadVal;
          r_pv[i]   <= 1'b1;
        end
      end
    end
  end

  assign divBus.oLoad_ready = w_ready;
  assign divBus.oClk        = r_clk;
  assign divBus.oTick       = r_tick;
endmodule

// File: tb/tb_prog_rate_div.sv
// Directed self-checking bench for prog_rate_div: start-up timing, boundary-aligned
// reloads, divide-by-two, enable drop, reset with a pending load, out-of-range loads.
module tb_prog_rate_div;
  logic iClk   = 1'b0;
  logic iRSt_n = 1'b1;
  int testCount = 0;
  int failCount = 0;

  prog_rate_div_if #(.NUM_CH(2), .CNT_W(8)) bus0 ();
  prog_rate_div_if #(.NUM_CH(3), .CNT_W(8)) bus1 ();

  prog_rate_div #(.NUM_CH(2), .CNT_W(8), .DEFAULT_HALF(5)) dut (
    .iClk(iClk), .iRSt_n(iRSt_n), .divBus(bus0.slave)
  );

  prog_rate_div #(.NUM_CH(3), .CNT_W(8), .DEFAULT_HALF(5)) dut3 (
    .iClk(iClk), .iRSt_n(iRSt_n), .divBus(bus1.slave)
  );

  always #5 iClk = ~iClk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] en, input logic valid,
                               input logic ch, input logic [7:0] half);
    bus0.iEn         = en;
    bus0.iLoad_valid = valid;
    bus0.iLoad_ch    = ch;
    bus0.iLoad_half  = half;
  endtask

  // Half-period 5 from a fresh start: rise at edge 5, period 10.
  function automatic logic expSlow(int k);
    return ((k / 5) % 2) == 1;
  endfunction

  function automatic logic expSlowTick(int k);
    return (k % 10) == 5;
  endfunction

  task automatic checkFreshStart(input string phase);
    for (int k = 1; k <= 20; k++) begin
      @(negedge iClk);
      checkOutput($sformatf("%s_clk_k%0d", phase, k), 32'(bus0.oClk),
                  expSlow(k) ? 32'h3 : 32'h0);
      checkOutput($sformatf("%s_tick_k%0d", phase, k), 32'(bus0.oTick),
                  expSlowTick(k) ? 32'h3 : 32'h0);
    end
  endtask

  initial begin
    logic e0, e1, t0, t1;
    applyStimulus(2'b00, 1'b0, 1'b0, 8'd0);
    bus1.iEn         = '0;
    bus1.iLoad_valid = 1'b0;
    bus1.iLoad_ch    = '0;
    bus1.iLoad_half  = '0;

    // Asynchronous reset, observed before any clock edge.
    #1 iRSt_n = 1'b0;
    #3;
    checkOutput("reset_clk", 32'(bus0.oClk), 32'h0);
    checkOutput("reset_tick", 32'(bus0.oTick), 32'h0);
    checkOutput("reset_ready", 32'(bus0.oLoad_ready), 32'h1);
    @(negedge iClk);
    @(negedge iClk);
    iRSt_n = 1'b1;
    applyStimulus(2'b11, 1'b0, 1'b0, 8'd0);

    checkFreshStart("start");

    // Reload ch0 to 2 in the middle of its high phase; ch1 keeps period 10.
    for (int k = 21; k <= 41; k++) begin
      @(negedge iClk);
      e1 = expSlow(k);
      t1 = expSlowTick(k);
      e0 = (k < 30) ? expSlow(k) : (((k - 30) / 2) % 2) == 1;
      t0 = (k < 30) ? expSlowTick(k) : ((k - 30) % 4) == 2;
      checkOutput($sformatf("reload_clk_k%0d", k), 32'(bus0.oClk), 32'({e1, e0}));
      checkOutput($sformatf("reload_tick_k%0d", k), 32'(bus0.oTick), 32'({t1, t0}));
      case (k)
        26: begin
          #1 checkOutput("ready_ch0_idle", 32'(bus0.oLoad_ready), 32'h1);
          applyStimulus(2'b11, 1'b1, 1'b0, 8'd2);
        end
        27: begin
          checkOutput("ready_ch0_pending_k27", 32'(bus0.oLoad_ready), 32'h0);
          applyStimulus(2'b11, 1'b1, 1'b0, 8'd7);
        end
        28: begin
          checkOutput("ready_ch0_pending_k28", 32'(bus0.oLoad_ready), 32'h0);
          applyStimulus(2'b11, 1'b0, 1'b0, 8'd0);
        end
        29: checkOutput("ready_ch0_pending_k29", 32'(bus0.oLoad_ready), 32'h0);
        30: checkOutput("ready_ch0_applied", 32'(bus0.oLoad_ready), 32'h1);
        41: applyStimulus(2'b10, 1'b0, 1'b0, 8'd0);
        default: ;
      endcase
    end

    // Drop/re-enable ch0 while high, then divide-by-two on ch1 loaded while disabled.
    for (int k = 42; k <= 57; k++) begin
      @(negedge iClk);
      e0 = (k < 44) ? 1'b0 : (((k - 43) / 2) % 2) == 1;
      t0 = (k < 44) ? 1'b0 : ((k - 43) % 4) == 2;
      e1 = (k <= 47) ? expSlow(k) : ((k <= 50) ? 1'b0 : (k % 2) == 1);
      t1 = (k <= 47) ? expSlowTick(k) : ((k <= 50) ? 1'b0 : (k % 2) == 1);
      checkOutput($sformatf("enable_clk_k%0d", k), 32'(bus0.oClk), 32'({e1, e0}));
      checkOutput($sformatf("enable_tick_k%0d", k), 32'(bus0.oTick), 32'({t1, t0}));
      case (k)
        43: applyStimulus(2'b11, 1'b0, 1'b0, 8'd0);
        47: applyStimulus(2'b01, 1'b0, 1'b0, 8'd0);
        48: begin
          applyStimulus(2'b01, 1'b0, 1'b1, 8'd0);
          #1 checkOutput("ready_ch1_idle", 32'(bus0.oLoad_ready), 32'h1);
          applyStimulus(2'b01, 1'b1, 1'b1, 8'd0);
        end
        49: begin
          applyStimulus(2'b01, 1'b0, 1'b1, 8'd0);
          checkOutput("ready_ch1_pending", 32'(bus0.oLoad_ready), 32'h0);
        end
        50: begin
          checkOutput("ready_ch1_applied", 32'(bus0.oLoad_ready), 32'h1);
          applyStimulus(2'b11, 1'b0, 1'b1, 8'd0);
        end
        56: begin
          applyStimulus(2'b11, 1'b0, 1'b0, 8'd0);
          #1 checkOutput("ready_ch0_free", 32'(bus0.oLoad_ready), 32'h1);
          applyStimulus(2'b11, 1'b1, 1'b0, 8'd3);
        end
        default: ;
      endcase
    end

    // Reset mid-period with ch0 pending: outputs clear at once, pending is dropped.
    applyStimulus(2'b11, 1'b0, 1'b0, 8'd0);
    checkOutput("ready_ch0_before_reset", 32'(bus0.oLoad_ready), 32'h0);
    #2 iRSt_n = 1'b0;
    #1;
    checkOutput("midreset_clk", 32'(bus0.oClk), 32'h0);
    checkOutput("midreset_tick", 32'(bus0.oTick), 32'h0);
    checkOutput("midreset_ready", 32'(bus0.oLoad_ready), 32'h1);
    @(negedge iClk);
    @(negedge iClk);
    iRSt_n = 1'b1;
    checkFreshStart("restart");

    // Out-of-range load on the three-channel instance is swallowed.
    @(negedge iClk);
    bus1.iLoad_ch   = 2'd3;
    bus1.iLoad_half = 8'd9;
    #1 checkOutput("oob_ready", 32'(bus1.oLoad_ready), 32'h1);
    bus1.iLoad_valid = 1'b1;
    @(negedge iClk);
    bus1.iLoad_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      bus1.iLoad_ch = 2'(c);
      #1 checkOutput($sformatf("oob_ready_ch%0d", c), 32'(bus1.oLoad_ready), 32'h1);
    end
    bus1.iEn = 3'b111;
    for (int k = 1; k <= 5; k++) begin
      @(negedge iClk);
      checkOutput($sformatf("oob_clk_k%0d", k), 32'(bus1.oClk),
                  (k == 5) ? 32'h7 : 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule

// File: doc/prog_rate_div.md
PROG_RATE_DIV -- requirements
Module: prog_rate_div

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent divider channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32: width of the half-period counter and of the load value.
REQ-003 SHALL have parameter DEFAULT_HALF, default 50_000_000: half-period in iClk cycles after reset (1 Hz at 100 MHz).
REQ-004 SHALL have localparam CH_W = max(1, clog2(NUM_CH)).
REQ-005 iClk  input  1  system clock (100 MHz nominal).
REQ-006 iRSt_n  input  1  reset, asynchronous, active-low.
REQ-007 iEn  input  NUM_CH  per-channel run enable.
REQ-008 iLoad_valid  input  1  half-period load request.
REQ-009 iLoad_ch  input  CH_W  target channel of the load.
REQ-010 iLoad_half  input  CNT_W  new half-period, in iClk cycles.
REQ-011 oLoad_ready  output  1  load slot available for iLoad_ch.
REQ-012 oClk  output  NUM_CH  per-channel 50%-duty divided square wave.
REQ-013 oTick  output  NUM_CH  one-cycle pulse marking each rising edge of oClk.

Function
REQ-014 Each channel SHALL hold active half-period H, counter cnt, pending value P and pending flag pv.
REQ-015 With iEn[i]=1, cnt[i] SHALL increment each cycle; when cnt[i] >= H[i]-1, cnt[i] SHALL clear to 0 and oClk[i] SHALL toggle.
REQ-016 Each oClk[i] level SHALL last exactly H[i] cycles; oClk[i] SHALL first rise on the H[i]-th enabled rising edge of iClk.
REQ-017 oTick[i] SHALL be registered and high for exactly the cycle in which oClk[i] is first 1 after a 0->1 toggle; it SHALL never be high while iEn[i]=0.
REQ-018 A loaded value of 0 SHALL be stored as 1, giving oClk toggling every cycle (iClk/2).
REQ-019 oLoad_ready SHALL be combinational: 1 when iLoad_ch >= NUM_CH, otherwise ~pv[iLoad_ch].
REQ-020 A load SHALL be accepted when iLoad_valid && oLoad_ready; this sets P[iLoad_ch] and pv[iLoad_ch] on the next edge.
REQ-021 A load with iLoad_ch >= NUM_CH SHALL be accepted and discarded with no state change.
REQ-022 For an enabled channel, pending P SHALL become H only on the cycle cnt clears and oClk toggles (half-period boundary), clearing pv in the same cycle; there SHALL be no truncated or stretched level (glitch-free switching).
REQ-023 For a disabled channel, pending P SHALL become H on the edge after acceptance.
REQ-024 With iEn[i]=0, cnt[i] SHALL be held at 0 and oClk[i] and oTick[i] at 0 on the next edge; re-enable SHALL restart per REQ-016.
REQ-025 If boundary-apply and a new accept on the same channel coincide, the apply SHALL take the old P; the accept cannot occur, since ready=0 while pv=1.
REQ-026 Channels SHALL be fully independent; a load to one channel SHALL not disturb the others.

Reset
REQ-027 On iRSt_n=0, asynchronously: all cnt=0, H=DEFAULT_HALF (or 1 if 0), P=0, pv=0, oClk=0, oTick=0.
REQ-028 Reset asserted mid-period or with pv=1 SHALL discard the pending load; after release, behaviour SHALL equal a fresh start.

Verification (NUM_CH=2, CNT_W=8, DEFAULT_HALF=5)
REQ-029 Release reset, iEn=2'b11 -> oClk[0] rises at the 5th edge, period 10 cycles, oTick[0] one pulse per 10 cycles, channel 1 identical.
REQ-030 Mid-high-phase, load ch0 half=2 -> current high phase completes its full 5 cycles, then levels of 2 cycles; oLoad_ready(ch0)=0 until the boundary.
REQ-031 Load ch1 half=0 while iEn[1]=0, then enable -> oClk[1] toggles every cycle, oTick[1] high every other cycle.
REQ-032 Load with iLoad_ch=3 -> oLoad_ready=1, accepted, no change on either channel; a second load to ch0 while pv[0]=1 -> ready=0, not taken.
REQ-033 Drop iEn[0] with oClk[0]=1 -> oClk[0]=0 next cycle, no oTick; re-enable -> first rise after H cycles.
REQ-034 Assert iRSt_n low mid-period with pv[0]=1 -> outputs 0 immediately; after release, H=5 on both channels and the pending value is lost.
